// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard signals of the multi-port register file.
// master = decode/issue + writeback side, slave = the register file.
interface regfile_mp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 1
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NR*AW-1:0]    rd_idx;
  logic [NR*WIDTH-1:0] rd_data;
  logic [NR-1:0]       rd_busy;
  logic [NW-1:0]       wr_en;
  logic [NW*AW-1:0]    wr_idx;
  logic [NW*WIDTH-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_idx;
  logic [DEPTH-1:0]    busy_vec;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, sb_set, sb_idx,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, sb_set, sb_idx,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NR combinational read ports, NW synchronous write ports, per-register busy
// scoreboard, optional hardwired-zero x0.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write data (and busy) forwarded to reads.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  // Next array contents: ports applied in ascending order so the highest port wins.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NW; w++) begin
      if (bus.wr_en[w] && !(ZeroEn && bus.wr_idx[w*AW +: AW] == '0)) begin
        mem_d[bus.wr_idx[w*AW +: AW]] = bus.wr_data[w*WIDTH +: WIDTH];
      end
    end
  end

  // Next scoreboard: writeback clears, then issue sets (newer producer stays pending).
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NW; w++) begin
      if (bus.wr_en[w]) begin
        busy_d[bus.wr_idx[w*AW +: AW]] = 1'b0;
      end
    end
    if (bus.sb_set) begin
      busy_d[bus.sb_idx] = 1'b1;
    end
    if (ZeroEn) begin
      busy_d[0] = 1'b0;
    end
  end

  // Array and scoreboard state; reset discards any same-cycle write or issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Scoreboard reads as zero while reset is held.
  always_comb begin
    bus.busy_vec = rst ? '0 : busy_q;
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign idx = bus.rd_idx[p*AW +: AW];

    // Stored value, optionally overridden by a same-cycle write, then x0/reset forcing.
    always_comb begin
      data = mem_q[idx];
      busy = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (bus.wr_en[w] && bus.wr_idx[w*AW +: AW] == idx) begin
          data = bus.wr_data[w*WIDTH +: WIDTH];
          busy = bus.sb_set && (bus.sb_idx == idx);
        end
      end
`endif
      if (rst || (ZeroEn && idx == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus.rd_data[p*WIDTH +: WIDTH] = data;
    assign bus.rd_busy[p]                = busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, hand-written reset/forwarding sequences and randomized
// traffic against an array-based reference model. Config: WIDTH=32 DEPTH=64 NR=3 NW=2.
module tb_regfile_mp;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 64;
  localparam int unsigned NR = 3;
  localparam int unsigned NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays, updated once per rising edge.
  logic [31:0] m_mem [D];
  logic [63:0] m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wr_en   = '0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    bus.sb_set  = 1'b0;
    bus.sb_idx  = '0;
  endtask

  task automatic set_rd(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    bus.rd_idx = {c, b, a};
  endtask

  task automatic model_clear();
    for (int r = 0; r < D; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  // Index of the highest enabled write port targeting idx, or -1.
  function automatic int last_writer(input logic [5:0] idx);
    for (int w = NW - 1; w >= 0; w--) begin
      if (bus.wr_en[w] && bus.wr_idx[w*6 +: 6] == idx) return w;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_data(input logic [5:0] idx);
    if (idx == 6'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (last_writer(idx) >= 0) return bus.wr_data[last_writer(idx)*32 +: 32];
`endif
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input logic [5:0] idx);
    if (idx == 6'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (last_writer(idx) >= 0) return bus.sb_set && (bus.sb_idx == idx);
`endif
    return m_busy[idx];
  endfunction

  task automatic model_edge();
    logic [63:0] nb;
    nb = m_busy;
    for (int w = 0; w < NW; w++) begin
      if (bus.wr_en[w]) begin
        if (bus.wr_idx[w*6 +: 6] != 6'd0) m_mem[bus.wr_idx[w*6 +: 6]] = bus.wr_data[w*32 +: 32];
        nb[bus.wr_idx[w*6 +: 6]] = 1'b0;
      end
    end
    if (bus.sb_set) nb[bus.sb_idx] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
  endtask

  function automatic logic [5:0] rnd_idx();
    if ($urandom_range(0, 2) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(0, 7));
  endfunction

  typedef struct packed {
    logic [1:0]  wen;
    logic [5:0]  wi0;
    logic [31:0] wd0;
    logic [5:0]  wi1;
    logic [31:0] wd1;
    logic        sbs;
    logic [5:0]  sbi;
    logic [5:0]  ri0, ri1, ri2;
    logic [31:0] ed0, ed1, ed2;
    logic [2:0]  eb;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Each row: drive writes/issue for one edge, then read with the write side idle.
    vecs[0] = '{2'b01, 6'd3, 32'h12345678, 6'd0, 32'h0, 1'b0, 6'd0,
                6'd3, 6'd3, 6'd3, 32'h12345678, 32'h12345678, 32'h12345678, 3'b000};
    vecs[1] = '{2'b01, 6'd0, 32'hFFFFFFFF, 6'd0, 32'h0, 1'b0, 6'd0,
                6'd0, 6'd0, 6'd3, 32'h0, 32'h0, 32'h12345678, 3'b000};
    vecs[2] = '{2'b11, 6'd7, 32'h1, 6'd7, 32'h2, 1'b0, 6'd0,
                6'd7, 6'd3, 6'd0, 32'h2, 32'h12345678, 32'h0, 3'b000};
    vecs[3] = '{2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 1'b1, 6'd9,
                6'd9, 6'd7, 6'd0, 32'h0, 32'h2, 32'h0, 3'b001};
    vecs[4] = '{2'b10, 6'd0, 32'h0, 6'd9, 32'hAA, 1'b1, 6'd9,
                6'd9, 6'd9, 6'd7, 32'hAA, 32'hAA, 32'h2, 3'b011};
    vecs[5] = '{2'b01, 6'd9, 32'hBB, 6'd0, 32'h0, 1'b0, 6'd0,
                6'd9, 6'd0, 6'd3, 32'hBB, 32'h0, 32'h12345678, 3'b000};
    vecs[6] = '{2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 1'b1, 6'd0,
                6'd0, 6'd9, 6'd7, 32'h0, 32'hBB, 32'h2, 3'b000};
    vecs[7] = '{2'b11, 6'd6, 32'h55, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0,
                6'd5, 6'd6, 6'd7, 32'hDEADBEEF, 32'h55, 32'h2, 3'b000};
    vecs[8] = '{2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 1'b1, 6'd12,
                6'd12, 6'd5, 6'd9, 32'h0, 32'hDEADBEEF, 32'hBB, 3'b001};
    vecs[9] = '{2'b11, 6'd63, 32'h1111, 6'd62, 32'h2222, 1'b1, 6'd63,
                6'd63, 6'd62, 6'd12, 32'h1111, 32'h2222, 32'h0, 3'b101};

    idle();
    set_rd(6'd5, 6'd3, 6'd0);
    #2;
    check("reset rd_data0", 64'(bus.rd_data[31:0]), 64'h0);
    check("reset rd_busy", 64'(bus.rd_busy), 64'h0);
    check("reset busy_vec", bus.busy_vec, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = vecs[i].wen;
      bus.wr_idx  = {vecs[i].wi1, vecs[i].wi0};
      bus.wr_data = {vecs[i].wd1, vecs[i].wd0};
      bus.sb_set  = vecs[i].sbs;
      bus.sb_idx  = vecs[i].sbi;
      @(posedge clk);
      #1 idle();
      set_rd(vecs[i].ri0, vecs[i].ri1, vecs[i].ri2);
      #1;
      check($sformatf("vec%0d rd_data0", i), 64'(bus.rd_data[31:0]), 64'(vecs[i].ed0));
      check($sformatf("vec%0d rd_data1", i), 64'(bus.rd_data[63:32]), 64'(vecs[i].ed1));
      check($sformatf("vec%0d rd_data2", i), 64'(bus.rd_data[95:64]), 64'(vecs[i].ed2));
      check($sformatf("vec%0d rd_busy", i), 64'(bus.rd_busy), 64'(vecs[i].eb));
    end

    // Asynchronous reset mid-cycle, with a write and an issue pending on r5.
    set_rd(6'd5, 6'd63, 6'd0);
    #2;
    check("pre-reset r5", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    check("pre-reset busy_vec", bus.busy_vec, (64'h1 << 12) | (64'h1 << 63));
    bus.wr_en   = 2'b01;
    bus.wr_idx  = {6'd0, 6'd5};
    bus.wr_data = {32'h0, 32'h77};
    bus.sb_set  = 1'b1;
    bus.sb_idx  = 6'd5;
    rst = 1'b1;
    #1;
    check("async reset r5", 64'(bus.rd_data[31:0]), 64'h0);
    check("async reset busy_vec", bus.busy_vec, 64'h0);
    check("async reset rd_busy", 64'(bus.rd_busy), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    #1;
    check("post-reset r5 write dropped", 64'(bus.rd_data[31:0]), 64'h0);
    check("post-reset busy_vec", bus.busy_vec, 64'h0);

    // Read-during-write on r4.
    bus.wr_en   = 2'b01;
    bus.wr_idx  = {6'd0, 6'd4};
    bus.wr_data = {32'h0, 32'h11};
    @(posedge clk);
    #1 bus.wr_data = {32'h0, 32'hCAFEF00D};
    set_rd(6'd4, 6'd4, 6'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw r4 same cycle", 64'(bus.rd_data[31:0]), 64'hCAFEF00D);
`else
    check("rdw r4 same cycle", 64'(bus.rd_data[31:0]), 64'h11);
`endif
    check("rdw r4 busy", 64'(bus.rd_busy[0]), 64'h0);
    @(posedge clk);
    #1 idle();
    #1 check("rdw r4 next cycle", 64'(bus.rd_data[31:0]), 64'hCAFEF00D);

    // Both ports write r4 with issue to r4: forwarding picks port 1 and reports busy.
    bus.wr_en   = 2'b11;
    bus.wr_idx  = {6'd4, 6'd4};
    bus.wr_data = {32'hB0B0B0B0, 32'hA0A0A0A0};
    bus.sb_set  = 1'b1;
    bus.sb_idx  = 6'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw dual r4 data", 64'(bus.rd_data[63:32]), 64'hB0B0B0B0);
    check("rdw dual r4 busy", 64'(bus.rd_busy[1]), 64'h1);
`else
    check("rdw dual r4 data", 64'(bus.rd_data[63:32]), 64'hCAFEF00D);
    check("rdw dual r4 busy", 64'(bus.rd_busy[1]), 64'h0);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    check("dual r4 next data", 64'(bus.rd_data[63:32]), 64'hB0B0B0B0);
    check("dual r4 next busy", 64'(bus.rd_busy[1]), 64'h1);

    // Randomized traffic from a clean reset.
    rst = 1'b1;
    #1 rst = 1'b0;
    model_clear();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk);
      #1;
      for (int w = 0; w < NW; w++) begin
        bus.wr_en[w]          = ($urandom_range(0, 2) != 0);
        bus.wr_idx[w*6 +: 6]  = rnd_idx();
        bus.wr_data[w*32 +: 32] = $urandom();
      end
      bus.sb_set = ($urandom_range(0, 1) != 0);
      bus.sb_idx = rnd_idx();
      for (int p = 0; p < NR; p++) bus.rd_idx[p*6 +: 6] = rnd_idx();
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        check($sformatf("rand c%0d rd_data%0d", cyc, p), 64'(bus.rd_data[p*32 +: 32]),
              64'(exp_data(bus.rd_idx[p*6 +: 6])));
        check($sformatf("rand c%0d rd_busy%0d", cyc, p), 64'(bus.rd_busy[p]),
              64'(exp_busy(bus.rd_idx[p*6 +: 6])));
      end
      check($sformatf("rand c%0d busy_vec", cyc), bus.busy_vec, m_busy);
      @(posedge clk);
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
